// File: rtl/mac_seq.sv
// mac_seq: runs a 4-lane MAC (unsigned act x signed weight + psum) over an N-group dot product.
// The accumulator is owned here and fed back as the MAC's c operand; one psum is returned per job.

module mac_seq_mac #(
    parameter int unsigned bw      = 4,
    parameter int unsigned psum_bw = 16
) (
    input  logic [4*bw-1:0]    i_a,
    input  logic [4*bw-1:0]    i_b,
    input  logic [psum_bw-1:0] i_c,
    output logic [psum_bw-1:0] o_sum_c
);
    localparam int unsigned LANES  = 4;
    localparam int unsigned PROD_W = 2*bw + 1;

    logic signed [PROD_W-1:0] w_prod [LANES];

    // Zero-extend act to make it a non-negative signed operand; sum wraps at psum_bw.
    always_comb begin
        o_sum_c = i_c;
        for (int i = 0; i < int'(LANES); i++) begin
            w_prod[i] = PROD_W'($signed({1'b0, i_a[i*bw +: bw]})) *
                        PROD_W'($signed(i_b[i*bw +: bw]));
            o_sum_c   = o_sum_c + psum_bw'(w_prod[i]);
        end
    end
endmodule

module mac_seq #(
    parameter int unsigned bw      = 4,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned cnt_bw  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [cnt_bw-1:0]   num_grp,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*bw-1:0]     a_in,
    input  logic [4*bw-1:0]     b_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [psum_bw-1:0]  psum_out,
    output logic                busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [psum_bw-1:0]  r_acc;
    logic [psum_bw-1:0]  r_psum;
    logic [cnt_bw-1:0]   r_rem;
    logic [psum_bw-1:0]  w_mac;
    logic                w_take;
    logic                w_last;

    mac_seq_mac #(
        .bw      (bw),
        .psum_bw (psum_bw)
    ) u_mac (
        .i_a     (a_in),
        .i_b     (b_in),
        .i_c     (r_acc),
        .o_sum_c (w_mac)
    );

    assign w_take   = in_valid && in_ready;
    assign w_last   = w_take && (r_rem == cnt_bw'(1));
    assign psum_out = r_psum;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (num_grp == '0) ? S_DONE : S_ACC;
                end
            end
            S_ACC: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_ACC: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Accumulator, remaining-group counter and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc  <= '0;
            r_rem  <= '0;
            r_psum <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc <= '0;
                        r_rem <= num_grp;
                        if (num_grp == '0) begin
                            r_psum <= '0;
                        end
                    end
                end
                S_ACC: begin
                    if (w_take) begin
                        r_acc <= w_mac;
                        r_rem <= r_rem - cnt_bw'(1);
                        if (w_last) begin
                            r_psum <= w_mac;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_seq.sv
// Scoreboard bench for mac_seq: driver pushes model psums, a negedge monitor pops on out handshakes.

module tb_mac_seq;
    localparam int unsigned BW      = 4;
    localparam int unsigned PSUM_BW = 16;
    localparam int unsigned CNT_BW  = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [CNT_BW-1:0]    num_grp;
    logic                 in_valid;
    logic                 in_ready;
    logic [4*BW-1:0]      a_in;
    logic [4*BW-1:0]      b_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [PSUM_BW-1:0]   psum_out;
    logic                 busy;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q [$];
    logic [15:0] ga [$];
    logic [15:0] gb [$];
    logic [15:0] last_psum = '0;

    mac_seq #(.bw(BW), .psum_bw(PSUM_BW), .cnt_bw(CNT_BW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_grp   (num_grp),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .psum_out  (psum_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Dot product from the arithmetic definition, reduced mod 2^16.
    function automatic logic [15:0] ref_dot(input int n);
        int sum = 0;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 4; i++) begin
                logic [15:0] aw;
                logic [15:0] bw;
                int av;
                int bv;
                aw = ga[k];
                bw = gb[k];
                av = int'(aw[i*4 +: 4]);
                bv = int'(bw[i*4 +: 4]);
                if (bv >= 8) bv = bv - 16;
                sum += av * bv;
            end
        end
        return 16'(sum);
    endfunction

    // Monitor: compare whenever the DUT completes an output handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(psum_out), 32'hDEAD_BEEF);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    check("psum_out", 32'(psum_out), 32'(e));
                end
                last_psum = psum_out;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gap: 0 none, 1 every group, 2 random. hold: DONE cycles with out_ready=0.
    task automatic run_job(input int n, input int gap, input int hold, input bit poke);
        logic [15:0] e;
        e = ref_dot(n);
        exp_q.push_back(e);
        start   = 1'b1;
        num_grp = CNT_BW'(n);
        tick();
        start   = 1'b0;
        if (n == 0) check("zero_grp_in_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < n; k++) begin
            if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                a_in     = 16'($urandom);
                b_in     = 16'($urandom);
                tick();
            end
            in_valid = 1'b1;
            a_in     = ga[k];
            b_in     = gb[k];
            check("in_ready_acc", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        check("out_latency", 32'(out_valid), 32'd1);
        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                start   = 1'b1;
                num_grp = CNT_BW'($urandom_range(0, 5));
            end
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_psum", 32'(psum_out), 32'(e));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check("exit_busy", 32'(busy), 32'd0);
        check("exit_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic fill(input int n, input logic [15:0] a, input logic [15:0] b);
        ga.delete();
        gb.delete();
        for (int k = 0; k < n; k++) begin
            ga.push_back(a);
            gb.push_back(b);
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        num_grp   = '0;
        in_valid  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_psum", 32'(psum_out), 32'd0);
        reset = 1'b0;
        tick();

        // in_valid while idle must not start anything
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("idle_valid_busy", 32'(busy), 32'd0);

        fill(1, 16'h4321, 16'h1111);
        run_job(1, 0, 0, 1'b0);
        check("t1_psum", 32'(last_psum), 32'd10);

        fill(3, 16'hFFFF, 16'h8888);
        run_job(3, 1, 0, 1'b0);
        check("t2_psum", 32'(last_psum), 32'h0000_FA60);

        run_job(0, 0, 0, 1'b0);
        check("t3_psum", 32'(last_psum), 32'd0);

        fill(2, 16'h2357, 16'hF19A);
        run_job(2, 0, 5, 1'b1);

        // Abort after 2 of 4 groups, then a fresh one-group job
        start   = 1'b1;
        num_grp = CNT_BW'(4);
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            a_in     = 16'hFFFF;
            b_in     = 16'h7777;
            tick();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        check("t5_in_ready", 32'(in_ready), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_out_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        tick();
        fill(1, 16'h1111, 16'h1111);
        run_job(1, 0, 0, 1'b0);
        check("t5_psum", 32'(last_psum), 32'd4);

        fill(255, 16'hFFFF, 16'h7777);
        run_job(255, 0, 0, 1'b0);
        check("t6_psum", 32'(last_psum), 32'h0000_A25C);

        for (int j = 0; j < 25; j++) begin
            int n;
            n = int'($urandom_range(0, 12));
            ga.delete();
            gb.delete();
            for (int k = 0; k < n; k++) begin
                ga.push_back(16'($urandom));
                gb.push_back(16'($urandom));
            end
            run_job(n, 2, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        tick();
        tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
